raptor64_regfile_byp: RTL and testbench
=======================================

// Module: raptor64_regfile_byp
// PURPOSE
//  Parametrised register file with bypass network for the Raptor64 pipeline.
//  Generalises the 3-read/5-stage bypass file in read-port count, bypass depth, width and depth.
//  Adds per-stage bypass valid qualifiers and write-first read collision handling.
//  Adds a post-reset clear sequencer that zeroes the whole array before issue may start.
//  Sits between decode (read addresses) and the X/M1/M2/W/T result buses.
// PARAMETERS
//  DW      64   data width
//  AW      9    register address width; NREGS = 2**AW (32-register banks)
//  NRD     3    number of read ports
//  NBYP    5    bypass stages; index 0 = youngest (X), NBYP-1 = oldest (T)
//  PC_IDX  29   low-5-bit register index that reads as dpc
// PORTS
//  clk        in   1        clock; all state changes on rising edge
//  rst_n      in   1        synchronous reset, active low
//  advanceR   in   1        capture read addresses and launch array reads
//  advanceW   in   1        write-port clock enable
//  wIRvalid   in   1        write enable (qualified by advanceW)
//  wRt        in   AW       write address
//  wData      in   DW       write data
//  dR         in   NRD*AW   read addresses, port p at [p*AW +: AW]
//  dpc        in   64       PC value returned for register index PC_IDX
//  byp_rt     in   NBYP*AW  bypass target register per stage
//  byp_vld    in   NBYP     bypass stage valid
//  byp_data   in   NBYP*DW  bypass result per stage
//  nxt        out  NRD*DW   operand per port, valid the cycle after advanceR
//  busy       out  1        1 while clear sequencer runs; decode must stall
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state<=INIT, clr_cnt<=0, busy<=1
//   - registered read addresses <=0, collision flags <=0, so nxt=0
//  FSM:
//   - INIT: write 0 to array[clr_cnt] each cycle; clr_cnt++
//   - at clr_cnt==NREGS-1 -> RUN, busy<=0 next edge; INIT lasts exactly NREGS cycles
//   - RUN: stays until reset; rst_n low at any time, incl. mid-INIT, restarts INIT at 0
//   - in INIT advanceR and the write port are ignored; nxt held at 0
//  Write (RUN): array[wRt]<=wData when advanceW & wIRvalid. r0 of each bank may be written but always reads 0.
//  Read latency 1: on a posedge with advanceR, port p registers dR[p] as ra_q[p] and samples array[dR[p]].
//  Read collision: if the same edge writes wRt==dR[p], the registered array value is wData (write-first).
//  When advanceR=0, ra_q and array outputs hold.
//  nxt[p] is combinational from ra_q[p] and current-cycle bypass inputs, first match wins:
//   1. ra_q[p][4:0]==0 -> 0
//   2. ra_q[p][4:0]==PC_IDX -> dpc
//   3. lowest i with byp_vld[i] & byp_rt[i]==ra_q[p] -> byp_data[i]
//   4. else registered array word
//   - an invalid stage never matches, even with an equal tag
//  All NRD ports are independent; identical addresses on several ports are legal.
// STRUCTURE
//  Package raptor64_rf_pkg: state enum {INIT,RUN}, ZERO_LO=5'd0, PC_IDX default.
//  Sub-module raptor64_rf_bypass_mux (one per read port, generate loop): priority select, items 1-4.
//  Array: inferred NREGS x DW, single write port muxed between clear sequencer and wRt.
//  Array: NRD synchronous read ports (replicated banks acceptable).
// TESTING
//  1. Reset, then release -> busy=1 for exactly 2**AW cycles; every address then reads 0.
//  2. Write r5=0x1234 (advanceW=1,wIRvalid=1); later dR[0]=5 with advanceR=1, no bypass valid -> nxt[0]=0x1234 next cycle.
//  3. ra=r7: byp_vld=5'b00110, stages 1,2 tag 7 with data A,B -> nxt=A; byp_vld=5'b00100 -> B; byp_vld=0 -> array value.
//  4. Same edge writes r9=0xBEEF and reads dR[1]=9 -> nxt[1]=0xBEEF; read r32 (bank 1 r0) after writing it -> 0.
//  5. Read index 29 and 61 -> nxt=dpc; drive rst_n=0 mid-INIT (clr_cnt=100) -> clr_cnt restarts at 0, busy stays 1.

Source files
------------

// File: rtl/raptor64_regfile_byp_pkg.sv
// raptor64_rf_pkg
//   Shared types and constants for the Raptor64 register file with bypass.
//   rf_state_e  : clear-sequencer state (INIT clears the array, RUN is normal issue)
//   ZERO_LO     : low-5-bit register index that always reads as zero (r0 of each bank)
//   PC_IDX_DEF  : default low-5-bit register index that reads as the decode PC
package raptor64_rf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  localparam logic [4:0] ZERO_LO    = 5'd0;
  localparam int         PC_IDX_DEF = 29;

endpackage

// File: rtl/raptor64_regfile_byp_bypass_mux.sv
// raptor64_rf_bypass_mux
//   Operand select for one read port. Priority, highest first:
//     r0 of any bank -> 0, PC index -> dpc, youngest valid matching bypass
//     stage -> its data, otherwise the registered array word.
// Ports
//   ra        in   AW        registered read address for this port
//   dpc       in   64        decode PC
//   byp_rt    in   NBYP*AW   bypass target register per stage (0 = youngest)
//   byp_vld   in   NBYP      bypass stage valid
//   byp_data  in   NBYP*DW   bypass result per stage
//   arr_data  in   DW        array word captured with ra (write-first resolved)
//   nxt       out  DW        selected operand
module raptor64_rf_bypass_mux
  import raptor64_rf_pkg::*;
#(
  parameter int DW     = 64,
  parameter int AW     = 9,
  parameter int NBYP   = 5,
  parameter int PC_IDX = PC_IDX_DEF
) (
  input  logic [AW-1:0]      ra,
  input  logic [63:0]        dpc,
  input  logic [NBYP*AW-1:0] byp_rt,
  input  logic [NBYP-1:0]    byp_vld,
  input  logic [NBYP*DW-1:0] byp_data,
  input  logic [DW-1:0]      arr_data,
  output logic [DW-1:0]      nxt
);

  localparam logic [4:0] PC_LO = 5'(PC_IDX);

  logic          byp_hit;
  logic [DW-1:0] byp_word;

  // Scan oldest to youngest so the youngest valid match is the last one kept.
  always_comb begin
    byp_hit  = 1'b0;
    byp_word = '0;
    for (int i = NBYP - 1; i >= 0; i--) begin
      if (byp_vld[i] && (byp_rt[i*AW +: AW] == ra)) begin
        byp_hit  = 1'b1;
        byp_word = byp_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    if (ra[4:0] == ZERO_LO) begin
      nxt = '0;
    end else if (ra[4:0] == PC_LO) begin
      nxt = DW'(dpc);
    end else if (byp_hit) begin
      nxt = byp_word;
    end else begin
      nxt = arr_data;
    end
  end

endmodule

// File: rtl/raptor64_regfile_byp.sv
// raptor64_regfile_byp
//   Parametrised Raptor64 register file: NREGS x DW array, NRD synchronous
//   read ports with write-first collision handling, NBYP-stage bypass network,
//   and a post-reset clear sequencer that zeroes the array before issue.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   INIT  | clear sequencer writes 0 to array[clr_cnt]; reads/writes ignored
//   RUN   | normal operation; array written from wRt/wData, reads launched
//
// Ports
//   clk       in   1         clock, rising edge
//   rst_n     in   1         synchronous reset, active low
//   advanceR  in   1         capture read addresses and launch array reads
//   advanceW  in   1         write-port clock enable
//   wIRvalid  in   1         write enable (qualified by advanceW)
//   wRt       in   AW        write address
//   wData     in   DW        write data
//   dR        in   NRD*AW    read addresses, port p at [p*AW +: AW]
//   dpc       in   64        PC value returned for the PC register index
//   byp_rt    in   NBYP*AW   bypass target register per stage
//   byp_vld   in   NBYP      bypass stage valid
//   byp_data  in   NBYP*DW   bypass result per stage
//   nxt       out  NRD*DW    operand per port, valid the cycle after advanceR
//   busy      out  1         high while the clear sequencer runs
module raptor64_regfile_byp
  import raptor64_rf_pkg::*;
#(
  parameter int DW     = 64,
  parameter int AW     = 9,
  parameter int NRD    = 3,
  parameter int NBYP   = 5,
  parameter int PC_IDX = PC_IDX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advanceR,
  input  logic               advanceW,
  input  logic               wIRvalid,
  input  logic [AW-1:0]      wRt,
  input  logic [DW-1:0]      wData,
  input  logic [NRD*AW-1:0]  dR,
  input  logic [63:0]        dpc,
  input  logic [NBYP*AW-1:0] byp_rt,
  input  logic [NBYP-1:0]    byp_vld,
  input  logic [NBYP*DW-1:0] byp_data,
  output logic [NRD*DW-1:0]  nxt,
  output logic               busy
);

  localparam int NREGS = 1 << AW;
  localparam logic [AW-1:0] CLR_LAST = AW'(NREGS - 1);

  rf_state_e     state;
  logic [AW-1:0] clr_cnt;
  logic          busy_q;

  logic [DW-1:0] mem [NREGS];

  logic          run_wr;
  logic          rd_en;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  logic [AW-1:0] ra_q  [NRD];
  logic [DW-1:0] rd_q  [NRD];
  logic [NRD-1:0] col_q;
  logic [DW-1:0] wd_q;

  assign run_wr = (state == RUN) && advanceW && wIRvalid;
  assign rd_en  = (state == RUN) && advanceR;
  assign busy   = busy_q;

  // Single array write port shared by the clear sequencer and the pipeline.
  // Nothing is written while reset is asserted.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wRt;
    mem_wd = wData;
    if (rst_n) begin
      if (state == INIT) begin
        mem_we = 1'b1;
        mem_wa = clr_cnt;
        mem_wd = '0;
      end else begin
        mem_we = run_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          busy_q <= 1'b0;
        end
        default: begin
          state  <= INIT;
          clr_cnt <= '0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Addresses and collision flags are reset so nxt reads 0 (r0) until the
  // first read after the clear. A same-edge write to a read address is
  // resolved by a flag plus one shared copy of wData, which keeps the array
  // read path a plain synchronous read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      wd_q  <= '0;
      for (int p = 0; p < NRD; p++) begin
        ra_q[p] <= '0;
      end
    end else if (rd_en) begin
      wd_q <= wData;
      for (int p = 0; p < NRD; p++) begin
        ra_q[p]  <= dR[p*AW +: AW];
        col_q[p] <= run_wr && (wRt == dR[p*AW +: AW]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rd_en) begin
      for (int p = 0; p < NRD; p++) begin
        rd_q[p] <= mem[dR[p*AW +: AW]];
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [DW-1:0] arr_word;

    assign arr_word = col_q[g] ? wd_q : rd_q[g];

    raptor64_rf_bypass_mux #(
      .DW     (DW),
      .AW     (AW),
      .NBYP   (NBYP),
      .PC_IDX (PC_IDX)
    ) u_mux (
      .ra       (ra_q[g]),
      .dpc      (dpc),
      .byp_rt   (byp_rt),
      .byp_vld  (byp_vld),
      .byp_data (byp_data),
      .arr_data (arr_word),
      .nxt      (nxt[g*DW +: DW])
    );
  end

endmodule

// File: tb/tb_raptor64_regfile_byp.sv
module tb_raptor64_regfile_byp;
  localparam int DW     = 64;
  localparam int AW     = 9;
  localparam int NRD    = 3;
  localparam int NBYP   = 5;
  localparam int NREGS  = 512;
  localparam int PC_IDX = 29;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               advanceR = 1'b0;
  logic               advanceW = 1'b0;
  logic               wIRvalid = 1'b0;
  logic [AW-1:0]      wRt = '0;
  logic [DW-1:0]      wData = '0;
  logic [NRD*AW-1:0]  dR = '0;
  logic [63:0]        dpc = '0;
  logic [NBYP*AW-1:0] byp_rt = '0;
  logic [NBYP-1:0]    byp_vld = '0;
  logic [NBYP*DW-1:0] byp_data = '0;
  wire  [NRD*DW-1:0]  nxt;
  wire                busy;

  raptor64_regfile_byp #(
    .DW(DW), .AW(AW), .NRD(NRD), .NBYP(NBYP), .PC_IDX(PC_IDX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .advanceR(advanceR), .advanceW(advanceW),
    .wIRvalid(wIRvalid), .wRt(wRt), .wData(wData), .dR(dR), .dpc(dpc),
    .byp_rt(byp_rt), .byp_vld(byp_vld), .byp_data(byp_data),
    .nxt(nxt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural register contents plus, per port, the
  // address and array value latched by the last accepted read.
  logic [DW-1:0] model [NREGS];
  logic [AW-1:0] cap_a [NRD];
  logic [DW-1:0] cap_d [NRD];
  bit            running = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_nxt(input int p);
    int a;
    a = int'(cap_a[p]);
    if (a % 32 == 0) return 64'd0;
    if (a % 32 == PC_IDX) return dpc;
    for (int i = 0; i < NBYP; i++) begin
      if (byp_vld[i] && int'(byp_rt[i*AW +: AW]) == a) return byp_data[i*DW +: DW];
    end
    return cap_d[p];
  endfunction

  function automatic logic [63:0] port_out(input int p);
    return nxt[p*DW +: DW];
  endfunction

  task automatic set_rd(input int p, input int a);
    dR[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_byp(input int i, input int rt, input logic [63:0] d);
    byp_rt[i*AW +: AW]   = AW'(rt);
    byp_data[i*DW +: DW] = d;
  endtask

  // One clock edge; model updated with what the DUT should do at that edge.
  task automatic tick();
    bit do_rd;
    bit do_wr;
    do_rd = running && rst_n && advanceR;
    do_wr = running && rst_n && advanceW && wIRvalid;
    @(posedge clk);
    if (do_rd) begin
      for (int p = 0; p < NRD; p++) begin
        cap_a[p] = dR[p*AW +: AW];
        cap_d[p] = (do_wr && wRt == cap_a[p]) ? wData : model[cap_a[p]];
      end
    end
    if (do_wr) model[wRt] = wData;
    if (!rst_n) begin
      running = 1'b0;
      for (int p = 0; p < NRD; p++) cap_a[p] = '0;
    end
    #1;
  endtask

  task automatic check_ports(input string tag);
    #1;
    for (int p = 0; p < NRD; p++) chk($sformatf("%s_p%0d", tag, p), port_out(p), exp_nxt(p));
  endtask

  // Clear sequence with junk on the read and write ports, which must be ignored.
  task automatic wait_init(output int n, output bit leak);
    n = 0;
    leak = 1'b0;
    advanceR = 1'b1;
    advanceW = 1'b1;
    wIRvalid = 1'b1;
    wRt = 9'd5;
    wData = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int p = 0; p < NRD; p++) set_rd(p, 5 + p);
    while (n < 2000) begin
      tick();
      n++;
      if (!busy) break;
      if (nxt !== '0) leak = 1'b1;
    end
    advanceR = 1'b0;
    advanceW = 1'b0;
    wIRvalid = 1'b0;
    running = 1'b1;
    for (int r = 0; r < NREGS; r++) model[r] = '0;
  endtask

  initial begin
    int  n;
    bit  leak;
    logic [63:0] va, vb, vc;

    for (int r = 0; r < NREGS; r++) model[r] = '0;
    for (int p = 0; p < NRD; p++) begin
      cap_a[p] = '0;
      cap_d[p] = '0;
    end

    // 1. reset and clear sequence
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b1);
    chk("rst_nxt", nxt[63:0], 64'd0);
    rst_n = 1'b1;
    wait_init(n, leak);
    chk("init_len", n, 64'd512);
    chk("init_nxt_held", leak, 1'b0);
    for (int a = 0; a < NREGS; a += NRD) begin
      for (int p = 0; p < NRD; p++) set_rd(p, (a + p) % NREGS);
      advanceR = 1'b1;
      tick();
      advanceR = 1'b0;
      for (int p = 0; p < NRD; p++) chk($sformatf("clr_a%0d", (a + p) % NREGS), port_out(p), 64'd0);
    end

    // 2. write r5, read it back
    wRt = 9'd5; wData = 64'h1234; advanceW = 1'b1; wIRvalid = 1'b1;
    tick();
    advanceW = 1'b0; wIRvalid = 1'b0;
    tick();
    set_rd(0, 5); set_rd(1, 6); set_rd(2, 0);
    advanceR = 1'b1;
    tick();
    advanceR = 1'b0;
    chk("t2_r5", port_out(0), 64'h1234);
    check_ports("t2");

    // 3. bypass priority on r7
    wRt = 9'd7; wData = 64'h7777; advanceW = 1'b1; wIRvalid = 1'b1;
    tick();
    advanceW = 1'b0; wIRvalid = 1'b0;
    va = 64'hAAAA_0000_0000_000A;
    vb = 64'hBBBB_0000_0000_000B;
    vc = 64'hCCCC_0000_0000_000C;
    set_byp(0, 7, 64'hDEAD); set_byp(1, 7, va); set_byp(2, 7, vb);
    set_byp(3, 7, vc); set_byp(4, 8, 64'h4444);
    set_rd(0, 7);
    advanceR = 1'b1;
    tick();
    advanceR = 1'b0;
    byp_vld = 5'b00110; #1;
    chk("t3_stage1", port_out(0), va);
    byp_vld = 5'b00100; #1;
    chk("t3_stage2", port_out(0), vb);
    byp_vld = 5'b11000; #1;
    chk("t3_stage3", port_out(0), vc);
    byp_vld = 5'b00000; #1;
    chk("t3_array", port_out(0), 64'h7777);
    check_ports("t3");

    // 4. write-first collision and bank-1 r0
    wRt = 9'd9; wData = 64'hBEEF; advanceW = 1'b1; wIRvalid = 1'b1;
    set_rd(0, 7); set_rd(1, 9); set_rd(2, 9);
    advanceR = 1'b1;
    tick();
    advanceR = 1'b0; advanceW = 1'b0; wIRvalid = 1'b0;
    chk("t4_collide", port_out(1), 64'hBEEF);
    check_ports("t4");
    wRt = 9'd32; wData = 64'hDEAD_BEEF; advanceW = 1'b1; wIRvalid = 1'b1;
    tick();
    advanceW = 1'b0; wIRvalid = 1'b0;
    set_rd(2, 32);
    set_byp(0, 32, 64'h3232);
    byp_vld = 5'b00001;
    advanceR = 1'b1;
    tick();
    advanceR = 1'b0;
    chk("t4_r32", port_out(2), 64'd0);
    byp_vld = '0;

    // 5a. PC index in banks 0, 1 and 2
    dpc = {$urandom, $urandom};
    set_rd(0, 29); set_rd(1, 61); set_rd(2, 93);
    set_byp(1, 61, 64'h6161);
    byp_vld = 5'b00010;
    advanceR = 1'b1;
    tick();
    advanceR = 1'b0;
    chk("t5_pc29", port_out(0), dpc);
    chk("t5_pc61", port_out(1), dpc);
    chk("t5_pc93", port_out(2), dpc);
    byp_vld = '0;

    // random traffic against the model
    for (int it = 0; it < 400; it++) begin
      advanceR = 1'($urandom_range(0, 1));
      advanceW = 1'($urandom_range(0, 3) != 0);
      wIRvalid = 1'($urandom_range(0, 3) != 0);
      wRt      = AW'($urandom_range(0, 70));
      wData    = {$urandom, $urandom};
      for (int p = 0; p < NRD; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? int'(wRt) : int'($urandom_range(0, 70)));
      tick();
      dpc = {$urandom, $urandom};
      for (int i = 0; i < NBYP; i++)
        set_byp(i, int'(($urandom_range(0, 1) == 0) ? cap_a[$urandom_range(0, NRD-1)]
                                                     : AW'($urandom_range(0, 70))),
                {$urandom, $urandom});
      byp_vld = NBYP'($urandom);
      check_ports($sformatf("rnd%0d", it));
    end
    advanceR = 1'b0; advanceW = 1'b0; wIRvalid = 1'b0; byp_vld = '0;

    // 5b. reset in the middle of the clear restarts it from address 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_nxt", nxt[63:0], 64'd0);
    rst_n = 1'b1;
    wait_init(n, leak);
    chk("reinit_len", n, 64'd512);
    set_rd(0, 5); set_rd(1, 7); set_rd(2, 9);
    advanceR = 1'b1;
    tick();
    advanceR = 1'b0;
    check_ports("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
